// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART link unit: command codes, FSM encodings and bit-timing helper.
// Optional receive timeout in the top is enabled by defining UART_RX_TIMEOUT_EN.
package uart_link_pkg;

    localparam logic [2:0] CMD_NOP       = 3'b000;
    localparam logic [2:0] CMD_SEND_WORD = 3'b001;
    localparam logic [2:0] CMD_RECV_WORD = 3'b010;
    localparam logic [2:0] CMD_SEND_BYTE = 3'b011;
    localparam logic [2:0] CMD_RECV_BYTE = 3'b100;

    // Width of the bit-timing counters; covers CLKS_PER_BIT well beyond 50 MHz / 9600.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_RX   = 3'd2,
        ST_DONE = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic cmd_valid(input logic [2:0] c);
        return (c == CMD_SEND_WORD) || (c == CMD_RECV_WORD) ||
               (c == CMD_SEND_BYTE) || (c == CMD_RECV_BYTE);
    endfunction

    function automatic logic cmd_is_send(input logic [2:0] c);
        return (c == CMD_SEND_WORD) || (c == CMD_SEND_BYTE);
    endfunction

    function automatic logic cmd_is_word(input logic [2:0] c);
        return (c == CMD_SEND_WORD) || (c == CMD_RECV_WORD);
    endfunction

endpackage

// File: rtl/uart_link_unit_rx.sv
// 8N1 receive deserializer: 2-FF synchronizer, start qualification at half bit, centre sampling, stop check.
// Held in its idle state whenever en is low; the synchronizer keeps running regardless.
module uart_rx_deser
    import uart_link_pkg::*;
#(
    parameter int CPB = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);

    rx_state_t        rs_q, rs_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            rs_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rs_q    <= rs_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        rs_d      = rs_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        if (!en) begin
            rs_d  = RX_IDLE;
            cnt_d = '0;
            bit_d = '0;
        end else begin
            case (rs_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        rs_d  = RX_START;
                        cnt_d = '0;
                    end
                end
                // A line back high at mid-start is a glitch, not a frame.
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d = '0;
                        bit_d = '0;
                        rs_d  = sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d   = '0;
                        shreg_d = {sync2_q, shreg_q[7:1]};
                        if (bit_q == 3'd7) rs_d = RX_STOP;
                        else               bit_d = bit_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d = '0;
                        rs_d  = RX_IDLE;
                        if (sync2_q) byte_vld  = 1'b1;
                        else         frame_err = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: rs_d = RX_IDLE;
            endcase
        end
    end

    assign rx_byte   = shreg_q;
    assign dbg_state = rs_q;

endmodule

// File: rtl/uart_link_unit.sv
// UART link unit: executes core UART commands (8N1, LSB first, words as 4 bytes low byte first).
// Define UART_RX_TIMEOUT_EN to bound receive waits at TIMEOUT_CYCLES.
module uart_link_unit
    import uart_link_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD           = 115_200,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  uartc,
    input  logic [31:0] write_value,
    input  logic        rx,
    output logic        tx,
    output logic        wb_flag,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        rx_err,
    output logic [4:0]  dbg_state
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(CPB);

    // Handshake: a command is accepted in IDLE on the first cycle uartc carries a valid code;
    // wb_flag is the single-cycle completion, and uartc must return to NOP before the next accept.
    state_t           state_q, state_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       last_idx_q, last_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             tx_q, tx_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             rx_err_q, rx_err_d;

    logic       rx_en;
    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_ferr;
    logic [1:0] rx_dbg;
    logic [7:0] tx_byte;
    logic       tx_bit;
    logic       timeout;

`ifdef UART_RX_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
    assign timeout = (timer_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    uart_rx_deser #(
        .CPB(CPB)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .en        (rx_en),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_vld  (rx_vld),
        .frame_err (rx_ferr),
        .dbg_state (rx_dbg)
    );

    assign rx_en = (state_q == ST_RX);

    // Frame position 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_comb begin
        tx_byte = data_q[{byte_idx_q, 3'b000} +: 8];
        if (bit_idx_q == 4'd0)      tx_bit = 1'b0;
        else if (bit_idx_q == 4'd9) tx_bit = 1'b1;
        else                        tx_bit = tx_byte[3'(bit_idx_q - 4'd1)];
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        last_idx_d = last_idx_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        tx_d       = 1'b1;
        wb_data_d  = wb_data_q;
        rx_err_d   = rx_err_q;
`ifdef UART_RX_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid(uartc)) begin
                    last_idx_d = cmd_is_word(uartc) ? 2'd3 : 2'd0;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    baud_cnt_d = '0;
                    rx_err_d   = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
                    timer_d    = '0;
`endif
                    if (cmd_is_send(uartc)) begin
                        data_d  = write_value;
                        state_d = ST_TX;
                    end else begin
                        data_d  = '0;
                        state_d = ST_RX;
                    end
                end
            end
            // tx_q lags the frame position by one cycle, so the final stop bit is
            // held one extra count to let the line finish it before completing.
            ST_TX: begin
                tx_d = tx_bit;
                if (bit_idx_q == 4'd9 && byte_idx_q == last_idx_q) begin
                    if (baud_cnt_q == BIT_FULL) state_d = ST_DONE;
                    else                        baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end else if (baud_cnt_q == BIT_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 4'd9) begin
                        bit_idx_d  = '0;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            ST_RX: begin
                if (rx_ferr) rx_err_d = 1'b1;
`ifdef UART_RX_TIMEOUT_EN
                timer_d = rx_vld ? '0 : timer_q + 32'd1;
                if (!rx_vld && timeout) begin
                    state_d   = ST_DONE;
                    wb_data_d = 32'hFFFF_FFFF;
                    rx_err_d  = 1'b1;
                end
`endif
                if (rx_vld) begin
                    data_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == last_idx_q) begin
                        state_d   = ST_DONE;
                        wb_data_d = data_d;
                    end
                end
            end
            ST_DONE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!cmd_valid(uartc)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            last_idx_q <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            wb_data_q  <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            last_idx_q <= last_idx_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
            wb_data_q  <= wb_data_d;
            rx_err_q   <= rx_err_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`endif

    assign tx        = tx_q;
    assign wb_flag   = (state_q == ST_DONE);
    assign wb_data   = wb_data_q;
    assign busy      = (state_q == ST_TX) || (state_q == ST_RX) || (state_q == ST_DONE);
    assign rx_err    = rx_err_q;
    assign dbg_state = {rx_dbg, state_q};

endmodule
